// File: rtl/inst_fetch_pkg.sv
// Shared defines for the instruction fetch stage: reset values, stall encoding
// and the fetch FSM state type.
package inst_fetch_pkg;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] ZeroWord  = 32'h0000_0000;
   localparam logic        Stop      = 1'b1;
   localparam logic        NoStop    = 1'b0;
   localparam logic        RstEnable = 1'b1;

   typedef enum logic [1:0] {
      S_REQ     = 2'd0,
      S_WAIT    = 2'd1,
      S_VALID   = 2'd2,
      S_DISCARD = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory request/response bus between the fetch stage and memory.
// inst_req/inst_addr form a request that is accepted in any cycle inst_gnt=1;
// inst_rvalid marks inst_rdata valid, one response per accepted request.
interface inst_fetch_if;

   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_gnt;
   logic        inst_rvalid;
   logic [31:0] inst_rdata;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_gnt,
      input  inst_rvalid,
      input  inst_rdata
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_gnt,
      output inst_rvalid,
      output inst_rdata
   );

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding memory request at a time, holds the
// fetched word until the pipeline advances, and drops responses killed by flush.
module inst_fetch
   import inst_fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         stall,
   input  logic               flush,
   input  logic [31:0]        new_pc,
   input  logic               branch_flag_i,
   input  logic [31:0]        branch_target_address_i,
   inst_fetch_if.master       imem,
   output logic [31:0]        if_pc,
   output logic [31:0]        if_inst,
   output logic               stallreq_if,
   output fetch_state_e       dbg_state
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  hold_q, hold_d;

   // Only stall[0] concerns this stage; the other bits belong to later stages.
   logic unused_stall;
   assign unused_stall = ^stall[5:1];

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         hold_q  <= ZeroWord;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      case (state_q)
         S_REQ: begin
            if (flush) begin
               pc_d    = new_pc;
               // A granted request still owes a response that must be dropped.
               state_d = imem.inst_gnt ? S_DISCARD : S_REQ;
            end else if (imem.inst_gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (flush) begin
               pc_d    = new_pc;
               state_d = imem.inst_rvalid ? S_REQ : S_DISCARD;
            end else if (imem.inst_rvalid) begin
               hold_d  = imem.inst_rdata;
               state_d = S_VALID;
            end
         end
         S_VALID: begin
            if (flush) begin
               pc_d    = new_pc;
               state_d = S_REQ;
            end else if (stall[0] == NoStop) begin
               pc_d    = branch_flag_i ? branch_target_address_i : pc_q + 32'd4;
               state_d = S_REQ;
            end
         end
         S_DISCARD: begin
            if (flush) pc_d = new_pc;
            // Leave once the orphaned response arrives, even if flushed again.
            if (imem.inst_rvalid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
   end

   always_comb begin
      imem.inst_req  = 1'b0;
      imem.inst_addr = ZeroWord;
      if_pc          = ZeroWord;
      if_inst        = ZeroWord;
      stallreq_if    = 1'b0;
      if (rst != RstEnable) begin
         imem.inst_req  = (state_q == S_REQ);
         imem.inst_addr = {pc_q[31:2], 2'b00};
         if_pc          = pc_q;
         if_inst        = (state_q == S_VALID) ? hold_q : ZeroWord;
         stallreq_if    = (state_q != S_VALID);
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a vector table for the fetch/stall flow, then
// hand-written sequences for branch, flush/discard, PC wrap and mid-fetch reset.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   localparam logic [31:0] I0 = 32'h1111_0000, I1 = 32'h2222_0004, I2 = 32'h3333_0008;
   localparam logic [31:0] I3 = 32'h4444_000C, I4 = 32'h5555_0010, I5 = 32'h6666_0014;
   localparam logic [31:0] I6 = 32'h7777_0020, I7 = 32'h8888_FFFC, I8 = 32'h9999_0000;
   localparam logic [31:0] STALE = 32'hDEAD_BEEF, STALE_RST = 32'hCAFE_F00D;
   localparam logic [31:0] JUNK  = 32'hBAD0_BAD0;

   typedef struct {
      logic        rst;
      logic        stall0;
      logic        flush;
      logic [31:0] new_pc;
      logic        br;
      logic [31:0] tgt;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_stallreq;
   } vec_t;

   logic         clk;
   logic         rst;
   logic [5:0]   stall;
   logic         flush;
   logic [31:0]  new_pc;
   logic         branch_flag_i;
   logic [31:0]  branch_target_address_i;
   logic [31:0]  if_pc;
   logic [31:0]  if_inst;
   logic         stallreq_if;
   fetch_state_e dbg_state;

   inst_fetch_if imem ();

   inst_fetch dut (
      .clk                     (clk),
      .rst                     (rst),
      .stall                   (stall),
      .flush                   (flush),
      .new_pc                  (new_pc),
      .branch_flag_i           (branch_flag_i),
      .branch_target_address_i (branch_target_address_i),
      .imem                    (imem),
      .if_pc                   (if_pc),
      .if_inst                 (if_inst),
      .stallreq_if             (stallreq_if),
      .dbg_state               (dbg_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic        prev_valid = 1'b0;
   logic        stale_seen = 1'b0;
   vec_t        tbl[25];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic r, input logic s, input logic f,
                                input logic [31:0] np, input logic b, input logic [31:0] t,
                                input logic g, input logic v, input logic [31:0] d,
                                input logic er, input logic [31:0] ea, input logic [31:0] ep,
                                input logic [31:0] ei, input logic es);
      vec_t x;
      x.rst = r; x.stall0 = s; x.flush = f; x.new_pc = np; x.br = b; x.tgt = t;
      x.gnt = g; x.rvalid = v; x.rdata = d;
      x.e_req = er; x.e_addr = ea; x.e_pc = ep; x.e_inst = ei; x.e_stallreq = es;
      return x;
   endfunction

   // Driver: apply one cycle of inputs on the falling edge, check settled outputs.
   task automatic run_vec(input vec_t v, input string name);
      @(negedge clk);
      rst                     = v.rst;
      stall                   = {5'($urandom_range(0, 31)), v.stall0};
      flush                   = v.flush;
      new_pc                  = v.new_pc;
      branch_flag_i           = v.br;
      branch_target_address_i = v.tgt;
      imem.inst_gnt           = v.gnt;
      imem.inst_rvalid        = v.rvalid;
      imem.inst_rdata         = v.rdata;
      #1;
      chk({name, "/inst_req"},    {31'd0, imem.inst_req}, {31'd0, v.e_req});
      chk({name, "/inst_addr"},   imem.inst_addr,         v.e_addr);
      chk({name, "/if_pc"},       if_pc,                  v.e_pc);
      chk({name, "/if_inst"},     if_inst,                v.e_inst);
      chk({name, "/stallreq_if"}, {31'd0, stallreq_if},   {31'd0, v.e_stallreq});
      if (if_inst === STALE || if_inst === STALE_RST) stale_seen = 1'b1;
      // Scoreboard: each new presentation must be the next expected instruction.
      if (!rst && stallreq_if === 1'b0 && !prev_valid) begin
         if (exp_q.size() == 0) begin
            chk({name, "/unexpected_present"}, if_inst, ZeroWord);
         end else begin
            chk({name, "/sb_order"}, if_inst, exp_q.pop_front());
         end
      end
      prev_valid = !rst && (stallreq_if === 1'b0);
   endtask

   initial begin
      rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
      branch_flag_i = 1'b0; branch_target_address_i = '0;
      imem.inst_gnt = 1'b0; imem.inst_rvalid = 1'b0; imem.inst_rdata = '0;

      exp_q = '{I0, I1, I2, I3, I4, I5, I6, I7, I8};

      //            rst s  f  new_pc  b  tgt     g  v  rdata  | req addr     pc       inst  stallreq
      tbl[0]  = mkv(1, 0, 0, 32'h0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,  32'h0,  32'h0, 0);
      tbl[1]  = mkv(1, 0, 0, 32'h0, 0, 32'h0,   1, 1, JUNK,    0, 32'h0,  32'h0,  32'h0, 0);
      tbl[2]  = mkv(0, 0, 0, 32'h0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h0,  32'h0,  32'h0, 1);
      tbl[3]  = mkv(0, 0, 0, 32'h0, 0, 32'h0,   0, 1, I0,      0, 32'h0,  32'h0,  32'h0, 1);
      tbl[4]  = mkv(0, 0, 0, 32'h0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,  32'h0,  I0,    0);
      tbl[5]  = mkv(0, 0, 0, 32'h0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h4,  32'h4,  32'h0, 1);
      tbl[6]  = mkv(0, 0, 0, 32'h0, 0, 32'h0,   0, 1, I1,      0, 32'h4,  32'h4,  32'h0, 1);
      tbl[7]  = mkv(0, 0, 0, 32'h0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h4,  32'h4,  I1,    0);
      tbl[8]  = mkv(0, 0, 0, 32'h0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h8,  32'h8,  32'h0, 1);
      tbl[9]  = mkv(0, 0, 0, 32'h0, 0, 32'h0,   0, 1, I2,      0, 32'h8,  32'h8,  32'h0, 1);
      tbl[10] = mkv(0, 0, 0, 32'h0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h8,  32'h8,  I2,    0);
      tbl[11] = mkv(0, 0, 0, 32'h0, 0, 32'h0,   1, 0, 32'h0,   1, 32'hC,  32'hC,  32'h0, 1);
      tbl[12] = mkv(0, 0, 0, 32'h0, 0, 32'h0,   0, 1, I3,      0, 32'hC,  32'hC,  32'h0, 1);
      tbl[13] = mkv(0, 0, 0, 32'h0, 0, 32'h0,   0, 0, 32'h0,   0, 32'hC,  32'hC,  I3,    0);
      tbl[14] = mkv(0, 0, 0, 32'h0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h10, 32'h10, 32'h0, 1);
      tbl[15] = mkv(0, 0, 0, 32'h0, 0, 32'h0,   0, 1, I4,      0, 32'h10, 32'h10, 32'h0, 1);
      tbl[16] = mkv(0, 1, 0, 32'h0, 0, 32'h0,   1, 1, JUNK,    0, 32'h10, 32'h10, I4,    0);
      tbl[17] = mkv(0, 1, 0, 32'h0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h10, 32'h10, I4,    0);
      tbl[18] = mkv(0, 1, 0, 32'h0, 1, 32'h999, 0, 0, 32'h0,   0, 32'h10, 32'h10, I4,    0);
      tbl[19] = mkv(0, 0, 0, 32'h0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h10, 32'h10, I4,    0);
      tbl[20] = mkv(0, 0, 0, 32'h0, 0, 32'h0,   0, 1, JUNK,    1, 32'h14, 32'h14, 32'h0, 1);
      tbl[21] = mkv(0, 0, 0, 32'h0, 0, 32'h0,   1, 0, 32'h0,   1, 32'h14, 32'h14, 32'h0, 1);
      tbl[22] = mkv(0, 0, 0, 32'h0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h14, 32'h14, 32'h0, 1);
      tbl[23] = mkv(0, 0, 0, 32'h0, 0, 32'h0,   0, 1, I5,      0, 32'h14, 32'h14, 32'h0, 1);
      tbl[24] = mkv(0, 0, 0, 32'h0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h14, 32'h14, I5,    0);

      for (int i = 0; i < 25; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      // Flush in REQ without grant, then a taken branch from VALID at 0x20.
      run_vec(mkv(0, 0, 1, 32'h20, 0, 32'h0,   0, 0, 32'h0, 1, 32'h18, 32'h18, 32'h0, 1), "req_flush");
      run_vec(mkv(0, 0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h0, 1, 32'h20, 32'h20, 32'h0, 1), "br_req");
      run_vec(mkv(0, 0, 0, 32'h0,  0, 32'h0,   0, 1, I6,    0, 32'h20, 32'h20, 32'h0, 1), "br_wait");
      run_vec(mkv(0, 0, 0, 32'h0,  1, 32'h100, 0, 0, 32'h0, 0, 32'h20, 32'h20, I6,    0), "br_valid");
      // Flush with grant -> DISCARD, re-flush inside DISCARD, then drop the response.
      run_vec(mkv(0, 0, 1, 32'h80, 0, 32'h0,   1, 0, 32'h0, 1, 32'h100, 32'h100, 32'h0, 1), "br_target");
      run_vec(mkv(0, 0, 1, 32'h40, 0, 32'h0,   0, 0, 32'h0, 0, 32'h80, 32'h80, 32'h0, 1), "disc_flush");
      run_vec(mkv(0, 0, 0, 32'h0,  0, 32'h0,   0, 1, STALE, 0, 32'h40, 32'h40, 32'h0, 1), "disc_drop");
      // Flush while waiting for 0x40; response arrives two cycles later.
      run_vec(mkv(0, 0, 0, 32'h0,   0, 32'h0, 1, 0, 32'h0, 1, 32'h40,  32'h40,  32'h0, 1), "req40");
      run_vec(mkv(0, 0, 1, 32'h180, 0, 32'h0, 0, 0, 32'h0, 0, 32'h40,  32'h40,  32'h0, 1), "wait_flush");
      run_vec(mkv(0, 0, 0, 32'h0,   0, 32'h0, 0, 0, 32'h0, 0, 32'h180, 32'h180, 32'h0, 1), "disc_idle");
      run_vec(mkv(0, 0, 0, 32'h0,   0, 32'h0, 0, 1, STALE, 0, 32'h180, 32'h180, 32'h0, 1), "disc_late");
      run_vec(mkv(0, 0, 0, 32'h0,   0, 32'h0, 1, 0, 32'h0, 1, 32'h180, 32'h180, 32'h0, 1), "req180");
      // Flush coinciding with the response in WAIT drops it; then PC wrap.
      run_vec(mkv(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 1, STALE, 0, 32'h180, 32'h180, 32'h0, 1), "wait_flush_rv");
      run_vec(mkv(0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1), "wrap_req");
      run_vec(mkv(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, I7,    0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1), "wrap_wait");
      run_vec(mkv(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, I7,    0), "wrap_valid");
      // Reset mid-WAIT with the response landing during and after reset.
      run_vec(mkv(0, 0, 1, 32'h200, 0, 32'h0, 0, 0, 32'h0,    1, 32'h0,   32'h0,   32'h0, 1), "wrap_addr");
      run_vec(mkv(0, 0, 0, 32'h0,   0, 32'h0, 1, 0, 32'h0,    1, 32'h200, 32'h200, 32'h0, 1), "req200");
      run_vec(mkv(1, 0, 0, 32'h0,   0, 32'h0, 0, 0, 32'h0,    0, 32'h0,   32'h0,   32'h0, 0), "rst_wait");
      run_vec(mkv(1, 0, 0, 32'h0,   0, 32'h0, 0, 1, STALE_RST, 0, 32'h0,  32'h0,   32'h0, 0), "rst_rvalid");
      run_vec(mkv(0, 0, 0, 32'h0,   0, 32'h0, 0, 1, STALE_RST, 1, 32'h0,  32'h0,   32'h0, 1), "post_rst_late");
      run_vec(mkv(0, 0, 0, 32'h0,   0, 32'h0, 1, 0, 32'h0,    1, 32'h0,   32'h0,   32'h0, 1), "post_rst_gnt");
      run_vec(mkv(0, 0, 0, 32'h0,   0, 32'h0, 0, 1, I8,       0, 32'h0,   32'h0,   32'h0, 1), "post_rst_wait");
      // Flush beats both stall and branch in VALID.
      run_vec(mkv(0, 1, 1, 32'h300, 1, 32'h500, 0, 0, 32'h0,  0, 32'h0,   32'h0,   I8,    0), "valid_flush");
      run_vec(mkv(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,  1, 32'h300, 32'h300, 32'h0, 1), "flush_target");

      chk("stale_never_shown", {31'd0, stale_seen}, 32'd0);
      chk("sb_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
